booth_r4_seq_mul: RTL and testbench

Parametrised iterative radix-4 Booth multiplier. It reuses one partial-product generator across WIDTH/2 (or WIDTH/2+1) cycles and accumulates the full 2·WIDTH-bit product. It replaces the fixed 8-bit, single-slot partial-product stage in the booth_MUL datapath with a start/busy/done engine that any width-generic arithmetic unit in the design can call.

---
 rtl/booth_pkg.sv | 32 +++
 rtl/booth_pp_sel.sv | 43 ++++
 rtl/booth_r4_seq_mul.sv | 135 +++++++++++++
 tb/tb_booth_r4_seq_mul.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recode digits
// and the triple-to-digit recoding function.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } booth_state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  // Triple is {q[2i+1], q[2i], q[2i-1]}.
  function automatic booth_digit_t booth_recode(input logic [2:0] triple);
    booth_digit_t d;
    case (triple)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: digit(triple) * mcand as a signed
// WIDTH+3 bit value; negation by invert-plus-one.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH+1:0] mcand,
  input  logic [2:0]       triple,
  output logic [WIDTH+2:0] pp
);

  localparam logic [WIDTH+2:0] PP_ONE = {{(WIDTH+2){1'b0}}, 1'b1};

  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;
  logic [WIDTH+2:0] mag;
  logic             neg;

  assign m1 = {mcand[WIDTH+1], mcand};
  assign m2 = {mcand, 1'b0};

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (booth_recode(triple))
      POS1: mag = m1;
      POS2: mag = m2;
      NEG1: begin
        mag = m1;
        neg = 1'b1;
      end
      NEG2: begin
        mag = m2;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
  end

  assign pp = neg ? ((~mag) + PP_ONE) : mag;

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier with start/busy/done handshake.
// Optional BOOTH_UNSIGNED_EN adds the tc port and an extra recode step.
module booth_r4_seq_mul
  import booth_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic             tc,
`endif
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    product
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int unsigned OW = WIDTH + 2;
`else
  localparam int unsigned OW = WIDTH;
`endif
  localparam int unsigned K    = OW / 2;
  localparam int unsigned CW   = $clog2(K);
  localparam int unsigned ACCW = PW + 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  booth_state_t state_q, state_d;
  logic         accept;
  logic         last;

  logic [OW-1:0]    a_q;
  logic [OW-1:0]    q_q;
  logic             q_m1_q;
  logic [CW-1:0]    cnt_q;
  logic [ACCW-1:0]  acc_q;
  logic [ACCW-1:0]  acc_next;
  logic [PW-1:0]    prod_q;

  logic [OW-1:0]    a_ext;
  logic [OW-1:0]    b_ext;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH+2:0] pp;
  logic [ACCW-1:0]  pp_ext;

`ifdef BOOTH_UNSIGNED_EN
  assign a_ext = {{2{tc & a[WIDTH-1]}}, a};
  assign b_ext = {{2{tc & b[WIDTH-1]}}, b};
  assign mcand = a_q;
`else
  assign a_ext = a;
  assign b_ext = b;
  assign mcand = {{2{a_q[WIDTH-1]}}, a_q};
`endif

  booth_pp_sel #(
    .WIDTH(WIDTH)
  ) u_pp_sel (
    .mcand (mcand),
    .triple({q_q[1:0], q_m1_q}),
    .pp    (pp)
  );

  // The multiplier register shifts right by 2 each step, so the triple is
  // always taken from its bottom; the partial product carries the 4^i weight.
  assign pp_ext   = {{(ACCW-(WIDTH+3)){pp[WIDTH+2]}}, pp};
  assign acc_next = acc_q + (pp_ext << {cnt_q, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      q_q    <= '0;
      q_m1_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      a_q    <= a_ext;
      q_q    <= b_ext;
      q_m1_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (state_q == RUN) begin
      q_q    <= {2'b00, q_q[OW-1:2]};
      q_m1_q <= q_q[1];
      cnt_q  <= cnt_q + CNT_ONE;
      acc_q  <= acc_next;
      if (last) prod_q <= acc_next[PW-1:0];
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed and random self-checking bench for booth_r4_seq_mul at WIDTH=8.
module tb_booth_r4_seq_mul;

`ifdef BOOTH_UNSIGNED_EN
  localparam int K = 5;
`else
  localparam int K = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
`ifdef BOOTH_UNSIGNED_EN
  logic        tc;
`endif
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total = 0;
  int bad   = 0;

  int   lat;
  int   nbusy;
  logic overlap;

  booth_r4_seq_mul #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
`ifdef BOOTH_UNSIGNED_EN
    .tc     (tc),
`endif
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic sgn);
    int p;
    if (sgn) p = int'($signed(x)) * int'($signed(y));
    else     p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  // Called at a negedge in IDLE or DONE; returns at the negedge of the done cycle.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    overlap = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) overlap = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef BOOTH_UNSIGNED_EN
    tc = 1'b1;
`endif
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product got=%h want=0000", product); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_signed_corner;
    run_op(8'h80, 8'h80);
    total++; if (lat !== K + 1) begin bad++; $display("FAIL corner_latency got=%0d want=%0d", lat, K + 1); end
    total++; if (nbusy !== K) begin bad++; $display("FAIL corner_busy_cycles got=%0d want=%0d", nbusy, K); end
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL corner_busy_with_done got=%b want=0", overlap); end
    total++; if (product !== 16'h4000) begin bad++; $display("FAIL corner_product got=%h want=4000", product); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL corner_done_pulse got=%b want=0", done); end
    total++; if (product !== 16'h4000) begin bad++; $display("FAIL corner_product_held got=%h want=4000", product); end
  endtask

  task automatic test_mixed_sign;
    run_op(8'd127, 8'hFF);
    total++; if (lat !== K + 1) begin bad++; $display("FAIL mixed_latency got=%0d want=%0d", lat, K + 1); end
    total++; if (product !== 16'hFF81) begin bad++; $display("FAIL mixed_product got=%h want=ff81", product); end
    @(negedge clk);
    run_op(8'h00, 8'h5A);
    total++; if (lat !== K + 1) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", lat, K + 1); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL zero_product got=%h want=0000", product); end
    @(negedge clk);
  endtask

`ifdef BOOTH_UNSIGNED_EN
  task automatic test_unsigned;
    tc = 1'b0;
    run_op(8'hFF, 8'hFF);
    total++; if (lat !== K + 1) begin bad++; $display("FAIL unsigned_latency got=%0d want=%0d", lat, K + 1); end
    total++; if (product !== 16'hFE01) begin bad++; $display("FAIL unsigned_product got=%h want=fe01", product); end
    @(negedge clk);
    tc = 1'b1;
    run_op(8'hFF, 8'hFF);
    total++; if (lat !== K + 1) begin bad++; $display("FAIL signed_ff_latency got=%0d want=%0d", lat, K + 1); end
    total++; if (product !== 16'h0001) begin bad++; $display("FAIL signed_ff_product got=%h want=0001", product); end
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back;
    int cyc;
    run_op(8'd10, 8'd7);
    total++; if (product !== 16'h0046) begin bad++; $display("FAIL b2b_first_product got=%h want=0046", product); end
    // Still in the DONE cycle: this start must be accepted.
    a = 8'd3;
    b = 8'hFB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept busy=%b done=%b want 1/0", busy, done); end
    total++; if (product !== 16'h0046) begin bad++; $display("FAIL b2b_old_held got=%h want=0046", product); end
    @(negedge clk);
    cyc = 2;
    a = 8'h55;
    b = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc !== K + 1) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", cyc, K + 1); end
    total++; if (product !== 16'hFFF1) begin bad++; $display("FAIL b2b_second_product got=%h want=fff1", product); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_run_start_ignored busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    a = 8'd100;
    b = 8'd50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL midrst_product got=%h want=0000", product); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_activity got=%0d want=0", seen); end
    run_op(8'd15, 8'd13);
    total++; if (lat !== K + 1) begin bad++; $display("FAIL midrst_next_latency got=%0d want=%0d", lat, K + 1); end
    total++; if (product !== 16'h00C3) begin bad++; $display("FAIL midrst_next_product got=%h want=00c3", product); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    logic [15:0] exp;
    for (int n = 0; n < 10000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
`ifdef BOOTH_UNSIGNED_EN
      rs = 1'($urandom_range(0, 1));
      tc = rs;
`else
      rs = 1'b1;
`endif
      exp = ref_mul(ra, rb, rs);
      run_op(ra, rb);
      total++; if (lat !== K + 1 || nbusy !== K || overlap !== 1'b0) begin
        bad++; $display("FAIL rand_timing n=%0d lat=%0d busy_cycles=%0d overlap=%b want %0d/%0d/0", n, lat, nbusy, overlap, K + 1, K);
      end
      total++; if (product !== exp) begin
        bad++; $display("FAIL rand_product n=%0d a=%h b=%h s=%b got=%h want=%h", n, ra, rb, rs, product, exp);
      end
    end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rand_done_pulse got=%b want=0", done); end
  endtask

  initial begin
    test_reset();
    test_signed_corner();
    test_mixed_sign();
`ifdef BOOTH_UNSIGNED_EN
    test_unsigned();
`endif
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
